// File: rtl/v35_intc.sv
// v35_intc: maskable, vectored interrupt controller for the V35-family CPU
// wrappers. NUM_CH request lines, each with an IC register (IF, MK, PR),
// per-channel edge/level selection (LMR) and polarity (ESR). ISPR tracks
// in-service priority levels so that nesting is correct. One request at a
// time is offered to the core through the irq_req/irq_ack/irq_fini handshake.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   ce_cycle       interrupt logic advances only when high
//   irq_in         raw request inputs, one per channel
//   reg_wr/reg_rd  SFR write / read strobes (act on every clk)
//   reg_addr       SFR offset
//   reg_din        write data
//   reg_dout       registered read data (valid the clk after reg_rd)
//   irq_req        request to the core
//   irq_vec        vector number, valid while irq_req=1
//   irq_ack        core acknowledge, one ce_cycle pulse
//   irq_fini       core end-of-interrupt (RETI), one ce_cycle pulse
module v35_intc #(
   parameter int         NUM_CH   = 3,
   parameter int         VEC_BASE = 24,
   parameter logic [7:0] IC_BASE  = 8'h4c
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce_cycle,
   input  logic [NUM_CH-1:0] irq_in,
   input  logic              reg_wr,
   input  logic              reg_rd,
   input  logic [7:0]        reg_addr,
   input  logic [7:0]        reg_din,
   output logic [7:0]        reg_dout,
   output logic              irq_req,
   output logic [7:0]        irq_vec,
   input  logic              irq_ack,
   input  logic              irq_fini
);

   localparam logic [7:0] ESR_ADDR  = 8'h40;
   localparam logic [7:0] LMR_ADDR  = 8'h41;
   localparam logic [7:0] ISPR_ADDR = 8'hfc;

   logic [NUM_CH-1:0]       if_q, if_d, mk_q, mk_d;
   logic [NUM_CH-1:0][2:0]  pr_q, pr_d;
   logic [NUM_CH-1:0]       esr_q, esr_d, lmr_q, lmr_d, prev_q, prev_d;
   logic [7:0]              ispr_q, ispr_d;
   logic                    req_q, req_d;
   logic [7:0]              vec_q, vec_d, dout_q, dout_d;
   logic [2:0]              ch_q, ch_d, lpr_q, lpr_d;

   // Arbitration result
   logic                    found, elig;
   logic [2:0]              best_ch, best_pr;
   logic [7:0]              pmask, rdata;

   // IC bits 5:3 are not stored
   logic                    unused_din;
   assign unused_din = ^reg_din[5:3];

   // Lowest PR wins; strict '<' keeps the lowest index on ties.
   always_comb begin
      found   = 1'b0;
      best_ch = 3'd0;
      best_pr = 3'd7;
      for (int n = 0; n < NUM_CH; n++) begin
         if (if_q[n] && !mk_q[n] && (!found || pr_q[n] < best_pr)) begin
            found   = 1'b1;
            best_ch = 3'(n);
            best_pr = pr_q[n];
         end
      end
      // Winner must be strictly higher than every level in service
      pmask = 8'h00;
      for (int i = 0; i < 8; i++)
         if (3'(i) <= best_pr) pmask[i] = 1'b1;
      elig = ((ispr_q & pmask) == 8'h00);
   end

   // Read mux (current register contents)
   always_comb begin
      rdata = 8'h00;
      if (reg_addr == ESR_ADDR)  rdata[NUM_CH-1:0] = esr_q;
      if (reg_addr == LMR_ADDR)  rdata[NUM_CH-1:0] = lmr_q;
      if (reg_addr == ISPR_ADDR) rdata = ispr_q;
      for (int n = 0; n < NUM_CH; n++)
         if (reg_addr == 8'(int'(IC_BASE) + n))
            rdata = {if_q[n], mk_q[n], 3'b000, pr_q[n]};
   end

   always_comb begin
      if_d   = if_q;
      mk_d   = mk_q;
      pr_d   = pr_q;
      esr_d  = esr_q;
      lmr_d  = lmr_q;
      prev_d = prev_q;
      ispr_d = ispr_q;
      req_d  = req_q;
      vec_d  = vec_q;
      ch_d   = ch_q;
      lpr_d  = lpr_q;
      dout_d = dout_q;

      if (reg_wr) begin
         if (reg_addr == ESR_ADDR) esr_d = reg_din[NUM_CH-1:0];
         if (reg_addr == LMR_ADDR) lmr_d = reg_din[NUM_CH-1:0];
         for (int n = 0; n < NUM_CH; n++) begin
            if (reg_addr == 8'(int'(IC_BASE) + n)) begin
               if_d[n] = reg_din[7];
               mk_d[n] = reg_din[6];
               pr_d[n] = reg_din[2:0];
            end
         end
      end else if (reg_rd) begin
         dout_d = rdata;
      end

      if (ce_cycle) begin
         prev_d = irq_in;
         // Hardware updates come after the register write so they win
         for (int n = 0; n < NUM_CH; n++) begin
            if (lmr_q[n]) begin
               if_d[n] = (irq_in[n] == esr_q[n]);
            end else begin
               if (req_q && irq_ack && ch_q == 3'(n)) if_d[n] = 1'b0;
               if (irq_in[n] != prev_q[n] && irq_in[n] == esr_q[n])
                  if_d[n] = 1'b1;
            end
         end

         // x & (x-1) drops the lowest set bit; zero stays zero
         if (irq_fini) ispr_d = ispr_q & (ispr_q - 8'd1);

         if (req_q) begin
            if (irq_ack) begin
               req_d         = 1'b0;
               ispr_d[lpr_q] = 1'b1;
            end
         end else if (found && elig) begin
            req_d = 1'b1;
            vec_d = 8'(VEC_BASE) + {5'd0, best_ch};
            ch_d  = best_ch;
            lpr_d = best_pr;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_q   <= '0;
         mk_q   <= '1;
         pr_q   <= {NUM_CH{3'd7}};
         esr_q  <= '0;
         lmr_q  <= '0;
         prev_q <= '0;
         ispr_q <= 8'h00;
         req_q  <= 1'b0;
         vec_q  <= 8'h00;
         ch_q   <= 3'd0;
         lpr_q  <= 3'd0;
         dout_q <= 8'h00;
      end else begin
         if_q   <= if_d;
         mk_q   <= mk_d;
         pr_q   <= pr_d;
         esr_q  <= esr_d;
         lmr_q  <= lmr_d;
         prev_q <= prev_d;
         ispr_q <= ispr_d;
         req_q  <= req_d;
         vec_q  <= vec_d;
         ch_q   <= ch_d;
         lpr_q  <= lpr_d;
         dout_q <= dout_d;
      end
   end

   assign reg_dout = dout_q;
   assign irq_req  = req_q;
   assign irq_vec  = vec_q;

endmodule

// File: tb/tb_v35_intc.sv
module tb_v35_intc;
   logic       clk = 1'b0;
   logic       reset, ce_cycle;
   logic [2:0] irq_in;
   logic       reg_wr, reg_rd;
   logic [7:0] reg_addr, reg_din, reg_dout;
   logic       irq_req, irq_ack, irq_fini;
   logic [7:0] irq_vec;

   int checks = 0;
   int errors = 0;

   v35_intc #(.NUM_CH(3), .VEC_BASE(24), .IC_BASE(8'h4c)) dut (
      .clk(clk), .reset(reset), .ce_cycle(ce_cycle), .irq_in(irq_in),
      .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
      .reg_din(reg_din), .reg_dout(reg_dout), .irq_req(irq_req),
      .irq_vec(irq_vec), .irq_ack(irq_ack), .irq_fini(irq_fini)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[21];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_din = d;
      tick();
      reg_wr = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
      reg_rd = 1'b1; reg_addr = a;
      tick();
      reg_rd = 1'b0;
      chk(name, reg_dout, exp);
   endtask

   task automatic ack();
      irq_ack = 1'b1; tick(); irq_ack = 1'b0;
   endtask

   task automatic fini();
      irq_fini = 1'b1; tick(); irq_fini = 1'b0;
   endtask

   task automatic wait_req(input string name, input logic [7:0] exp_vec);
      int n = 0;
      while (!irq_req && n < 20) begin
         tick();
         n++;
      end
      chk({name, "_req"}, {7'd0, irq_req}, 8'h01);
      chk({name, "_vec"}, irq_vec, exp_vec);
   endtask

   initial begin
      tbl[0]  = '{1'b0, 8'h4c, 8'h00, 8'h47};
      tbl[1]  = '{1'b0, 8'h4d, 8'h00, 8'h47};
      tbl[2]  = '{1'b0, 8'h4e, 8'h00, 8'h47};
      tbl[3]  = '{1'b0, 8'h40, 8'h00, 8'h00};
      tbl[4]  = '{1'b0, 8'h41, 8'h00, 8'h00};
      tbl[5]  = '{1'b0, 8'hfc, 8'h00, 8'h00};
      tbl[6]  = '{1'b0, 8'h4f, 8'h00, 8'h00};
      tbl[7]  = '{1'b0, 8'h00, 8'h00, 8'h00};
      tbl[8]  = '{1'b1, 8'h40, 8'hff, 8'h00};
      tbl[9]  = '{1'b0, 8'h40, 8'h00, 8'h07};
      tbl[10] = '{1'b1, 8'h41, 8'hf8, 8'h00};
      tbl[11] = '{1'b0, 8'h41, 8'h00, 8'h00};
      tbl[12] = '{1'b1, 8'h4c, 8'h3d, 8'h00};
      tbl[13] = '{1'b0, 8'h4c, 8'h00, 8'h05};
      tbl[14] = '{1'b1, 8'h50, 8'hff, 8'h00};
      tbl[15] = '{1'b0, 8'h50, 8'h00, 8'h00};
      tbl[16] = '{1'b1, 8'hfc, 8'hff, 8'h00};
      tbl[17] = '{1'b0, 8'hfc, 8'h00, 8'h00};
      tbl[18] = '{1'b1, 8'h40, 8'h00, 8'h00};
      tbl[19] = '{1'b1, 8'h4c, 8'h47, 8'h00};
      tbl[20] = '{1'b0, 8'h4c, 8'h00, 8'h47};

      reset = 1'b1; ce_cycle = 1'b1; irq_in = 3'b000;
      reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = 8'h00; reg_din = 8'h00;
      irq_ack = 1'b0; irq_fini = 1'b0;
      tick(); tick();
      reset = 1'b0;
      chk("rst_dout", reg_dout, 8'h00);
      chk("rst_req", {7'd0, irq_req}, 8'h00);
      chk("rst_vec", irq_vec, 8'h00);

      // Register map table
      foreach (tbl[i]) begin
         if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
         else rd_chk($sformatf("tbl%0d", i), tbl[i].addr, tbl[i].exp);
      end

      // Single edge request on ch1, exact two-ce_cycle latency
      wr(8'h4d, 8'h02);
      wr(8'h40, 8'h02);
      irq_in[1] = 1'b1;
      tick();
      chk("t2_req_k", {7'd0, irq_req}, 8'h00);
      tick();
      chk("t2_req_k1", {7'd0, irq_req}, 8'h01);
      chk("t2_vec", irq_vec, 8'd25);
      ack();
      chk("t2_req_ack", {7'd0, irq_req}, 8'h00);
      rd_chk("t2_ispr", 8'hfc, 8'h04);
      rd_chk("t2_ic1", 8'h4d, 8'h02);
      fini();
      rd_chk("t2_ispr_fini", 8'hfc, 8'h00);

      // Priority and nesting block: ch2 PR1 over ch0 PR5
      wr(8'h40, 8'h07);
      wr(8'h4c, 8'h05);
      wr(8'h4e, 8'h01);
      irq_in[0] = 1'b1; irq_in[2] = 1'b1;
      tick();
      tick();
      chk("t3_req", {7'd0, irq_req}, 8'h01);
      chk("t3_vec", irq_vec, 8'd26);
      ack();
      tick(); tick(); tick();
      chk("t3_blocked", {7'd0, irq_req}, 8'h00);
      rd_chk("t3_ispr", 8'hfc, 8'h02);
      fini();
      wait_req("t3_ch0", 8'd24);
      ack();
      rd_chk("t3_ispr_ch0", 8'hfc, 8'h20);
      fini();

      // Equal priority: lowest index first
      wr(8'h4c, 8'h03);
      wr(8'h4d, 8'h03);
      irq_in[1:0] = 2'b00;
      tick();
      irq_in[1:0] = 2'b11;
      tick();
      tick();
      chk("t4_req", {7'd0, irq_req}, 8'h01);
      chk("t4_vec", irq_vec, 8'd24);
      ack();
      tick();
      chk("t4_blocked", {7'd0, irq_req}, 8'h00);
      fini();
      wait_req("t4_ch1", 8'd25);
      // ack and fini together with ISPR empty: only the ack bit remains
      irq_ack = 1'b1; irq_fini = 1'b1;
      tick();
      irq_ack = 1'b0; irq_fini = 1'b0;
      rd_chk("t4_ispr_ackfini", 8'hfc, 8'h08);
      fini();
      ack();
      rd_chk("t4_stray_ack", 8'hfc, 8'h00);
      wr(8'h4c, 8'h47);
      wr(8'h4d, 8'h47);

      // Level mode on ch2, active low
      irq_in[2] = 1'b0;
      tick();
      wr(8'h40, 8'h03);
      wr(8'h41, 8'h04);
      wr(8'h4e, 8'h01);
      wait_req("t5_first", 8'd26);
      ack();
      rd_chk("t5_ic2_lvl", 8'h4e, 8'h81);
      rd_chk("t5_ispr", 8'hfc, 8'h02);
      fini();
      wait_req("t5_again", 8'd26);
      irq_in[2] = 1'b1;
      tick();
      rd_chk("t5_ic2_clr", 8'h4e, 8'h01);
      chk("t5_latched", {7'd0, irq_req}, 8'h01);
      ack();
      fini();
      tick(); tick(); tick();
      chk("t5_no_req", {7'd0, irq_req}, 8'h00);
      rd_chk("t5_ispr_end", 8'hfc, 8'h00);

      // Reset while a request is pending
      irq_in[2] = 1'b0;
      wait_req("t6_pre", 8'd26);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_req", {7'd0, irq_req}, 8'h00);
      chk("t6_vec", irq_vec, 8'h00);
      rd_chk("t6_ic0", 8'h4c, 8'h47);
      rd_chk("t6_ic1", 8'h4d, 8'h47);
      rd_chk("t6_ic2", 8'h4e, 8'h47);
      rd_chk("t6_ispr", 8'hfc, 8'h00);
      rd_chk("t6_lmr", 8'h41, 8'h00);

      // Software request with ce_cycle gating
      ce_cycle = 1'b0;
      wr(8'h4c, 8'h80);
      rd_chk("t7_ic0_noce", 8'h4c, 8'h80);
      tick(); tick();
      chk("t7_gated", {7'd0, irq_req}, 8'h00);
      ce_cycle = 1'b1;
      wait_req("t7_sw", 8'd24);
      ack();
      rd_chk("t7_ic0_ack", 8'h4c, 8'h00);
      rd_chk("t7_ispr", 8'hfc, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
